// File: rtl/lpf_pkg.sv
// Shared widths, kernel weights and rounding constants for the 3x3 binomial low-pass stage.
package lpf_pkg;
    localparam int PB = 8;
    localparam int XB = 10;
    localparam int YB = 10;
    localparam int VB = PB + 2;
    localparam int SB = PB + 4;
    localparam int K_EDGE = 1;
    localparam int K_MID = 2;
    localparam int ROUND = 8;
    localparam int SHIFT = 4;

    // 1-2-1 weighted sum shared by the vertical and horizontal passes
    function automatic logic [SB-1:0] w121(
        input logic [SB-1:0] a,
        input logic [SB-1:0] b,
        input logic [SB-1:0] c
    );
        return SB'(K_EDGE) * a + SB'(K_MID) * b + SB'(K_EDGE) * c;
    endfunction
endpackage

// File: rtl/lowpass3x3_if.sv
// Column-in / pixel-out bus of the 3x3 low-pass stage.
interface lowpass3x3_if;
    import lpf_pkg::*;
    logic            i_valid;
    logic [3*PB-1:0] i_col;
    logic [XB-1:0]   i_x;
    logic [YB-1:0]   i_y;
    logic            o_valid;
    logic [PB-1:0]   o_data;
    logic [XB-1:0]   o_x;
    logic [YB-1:0]   o_y;
    logic            o_frame_done;
    logic            o_seq_err;

    modport master (
        output i_valid, i_col, i_x, i_y,
        input  o_valid, o_data, o_x, o_y, o_frame_done, o_seq_err
    );
    modport slave (
        input  i_valid, i_col, i_x, i_y,
        output o_valid, o_data, o_x, o_y, o_frame_done, o_seq_err
    );
endinterface

// File: rtl/lpf_colsum.sv
// Vertical 1-2-1 sum of one pixel column (combinational).
module lpf_colsum
    import lpf_pkg::*;
(
    input  logic [3*PB-1:0] col_i,
    output logic [VB-1:0]   v_o
);
    assign v_o = VB'(w121(SB'(col_i[PB-1:0]),
                          SB'(col_i[2*PB-1:PB]),
                          SB'(col_i[3*PB-1:2*PB])));
endmodule

// File: rtl/lowpass3x3.sv
// Streaming 3x3 binomial low-pass: sliding column window, 3-stage pipeline,
// raster-order checking and end-of-frame marker.
module lowpass3x3
    import lpf_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input logic         clk,
    input logic         rst_n,
    lowpass3x3_if.slave bus
);
    logic [VB-1:0] v;
    logic [VB-1:0] w0_q, w1_q, w2_q;
    logic [XB-1:0] x0_q, x1_q, ox_q, px_q;
    logic [YB-1:0] y0_q, y1_q, oy_q, py_q;
    logic          v0_q, v1_q, ovalid_q, fd_q, err_q, seen_q;
    logic [SB-1:0] s_q, s_d;
    logic [PB-1:0] data_q, data_d;
    logic          full_d, seq_ok_d, err_d, fd_d;

    lpf_colsum u_colsum (
        .col_i (bus.i_col),
        .v_o   (v)
    );

    always_comb begin
        full_d   = (bus.i_x >= XB'(2)) && (bus.i_y >= YB'(2));
        seq_ok_d = 1'b0;
        // first column after reset opens a frame, so only x=0 is legal
        if (!seen_q) begin
            seq_ok_d = (bus.i_x == '0);
        end else begin
            seq_ok_d = ((bus.i_x == px_q + XB'(1)) && (bus.i_y == py_q))
                    || ((bus.i_x == '0)
                        && ((bus.i_y == py_q + YB'(1)) || (bus.i_y == '0)));
        end
        err_d  = err_q | (bus.i_valid & ~seq_ok_d);
        s_d    = w121(SB'(w2_q), SB'(w1_q), SB'(w0_q));
        data_d = PB'((s_q + SB'(ROUND)) >> SHIFT);
        fd_d   = v1_q && (x1_q == XB'(WIDTH - 2))
                      && (y1_q == YB'(HEIGHT - 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            v0_q     <= 1'b0;
            s_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            v1_q     <= 1'b0;
            data_q   <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            ovalid_q <= 1'b0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
            seen_q   <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
        end else begin
            v0_q     <= bus.i_valid && full_d;
            v1_q     <= v0_q;
            ovalid_q <= v1_q;
            fd_q     <= fd_d;
            err_q    <= err_d;
            if (bus.i_valid) begin
                w0_q   <= v;
                w1_q   <= w0_q;
                w2_q   <= w1_q;
                x0_q   <= bus.i_x;
                y0_q   <= bus.i_y;
                px_q   <= bus.i_x;
                py_q   <= bus.i_y;
                seen_q <= 1'b1;
            end
            if (v0_q) begin
                s_q  <= s_d;
                x1_q <= x0_q - XB'(1);
                y1_q <= y0_q - YB'(1);
            end
            if (v1_q) begin
                data_q <= data_d;
                ox_q   <= x1_q;
                oy_q   <= y1_q;
            end
        end
    end

    assign bus.o_valid      = ovalid_q;
    assign bus.o_data       = data_q;
    assign bus.o_x          = ox_q;
    assign bus.o_y          = oy_q;
    assign bus.o_frame_done = fd_q;
    assign bus.o_seq_err    = err_q;
endmodule
